// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_READ = 2'b01, RES_ALU = 2'b10} result_src_t;
    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RD1 = 2'b10} alu_src_a_t;
    typedef enum logic [1:0] {SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;

    // fetch: ir_write and pc_update gated by mem_ready; decode: opcode legality is checked
    typedef struct packed {
        logic        adr_src;
        logic        mem_write;
        logic        fetch;
        logic        pc_update;
        logic        branch;
        logic        reg_write;
        logic        decode;
        result_src_t result_src;
        alu_src_a_t  alu_src_a;
        alu_src_b_t  alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    endfunction

    function automatic ctrl_t control_word(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_DECODE: begin
                c.decode    = 1'b1;
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_READ;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: one state register holding the
// Moore control word, with mem_ready/zero/reset gating applied at the outputs.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       illegal_op
);

    state_t state, state_next;
    ctrl_t  ctrl;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // NOTE: the control word is registered from the next state so it appears in the
    // same cycle as the state itself, straight from flops; sequential state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ctrl  <= control_word(S_FETCH);
        end else begin
            state <= state_next;
            ctrl  <= control_word(state_next);
        end
    end

    // Strobes are forced low during reset so an abandoned instruction cannot write.
    assign pc_write   = !reset && (ctrl.pc_update || (ctrl.fetch && mem_ready) || (ctrl.branch && zero));
    assign ir_write   = !reset && ctrl.fetch && mem_ready;
    assign mem_write  = !reset && ctrl.mem_write;
    assign reg_write  = !reset && ctrl.reg_write;
    assign illegal_op = !reset && ctrl.decode && !is_supported(opcode);
    assign adr_src    = reset ? 1'b0 : ctrl.adr_src;
    assign result_src = reset ? 2'b00 : ctrl.result_src;
    assign alu_src_a  = reset ? 2'b00 : ctrl.alu_src_a;
    assign alu_src_b  = reset ? 2'b00 : ctrl.alu_src_b;
    assign alu_op     = reset ? 2'b00 : ctrl.alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver queues a hand-computed
// control vector per cycle, the monitor compares it against the DUT at negedge.
module tb_multicycle_controller;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal_op}
    localparam logic [13:0] W_RST     = 14'b0_0_0_0_0_00_00_00_00_0;
    localparam logic [13:0] W_F_RDY   = 14'b1_0_0_1_0_10_00_10_00_0;
    localparam logic [13:0] W_F_STALL = 14'b0_0_0_0_0_10_00_10_00_0;
    localparam logic [13:0] W_DEC     = 14'b0_0_0_0_0_00_01_01_00_0;
    localparam logic [13:0] W_DEC_ILL = 14'b0_0_0_0_0_00_01_01_00_1;
    localparam logic [13:0] W_MEMADR  = 14'b0_0_0_0_0_00_10_01_00_0;
    localparam logic [13:0] W_MEMRD   = 14'b0_1_0_0_0_00_00_00_00_0;
    localparam logic [13:0] W_MEMWB   = 14'b0_0_0_0_1_01_00_00_00_0;
    localparam logic [13:0] W_MEMWR   = 14'b0_1_1_0_0_00_00_00_00_0;
    localparam logic [13:0] W_EXER    = 14'b0_0_0_0_0_00_10_00_10_0;
    localparam logic [13:0] W_EXEI    = 14'b0_0_0_0_0_00_10_01_10_0;
    localparam logic [13:0] W_ALUWB   = 14'b0_0_0_0_1_00_00_00_00_0;
    localparam logic [13:0] W_JAL     = 14'b1_0_0_0_0_00_01_10_00_0;
    localparam logic [13:0] W_BEQ_T   = 14'b1_0_0_0_0_00_10_00_01_0;
    localparam logic [13:0] W_BEQ_N   = 14'b0_0_0_0_0_00_10_00_01_0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    logic [13:0] exp_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op)
    );

    // Drive one cycle of inputs and queue the expected control vector for that cycle.
    task automatic cyc(input logic rst, input logic [6:0] opc, input logic z, input logic mr,
                       input string name, input logic [13:0] exp);
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = opc;
        zero      = z;
        mem_ready = mr;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    initial begin : monitor
        logic [13:0] act, exp;
        string       name;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp  = exp_q.pop_front();
                name = name_q.pop_front();
                act  = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                        alu_src_a, alu_src_b, alu_op, illegal_op};
                tests++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL %s: got %b, expected %b", name, act, exp);
                end
            end
        end
    end

    initial begin : driver
        cyc(1, SW, 0, 1, "reset_0", W_RST);
        cyc(1, SW, 0, 1, "reset_1", W_RST);
        // sw interrupted by reset while stalled in MEMWRITE
        cyc(0, SW, 0, 1, "sw_fetch", W_F_RDY);
        cyc(0, SW, 0, 0, "sw_decode_mr0", W_DEC);
        cyc(0, SW, 0, 0, "sw_memadr_mr0", W_MEMADR);
        cyc(0, SW, 0, 0, "sw_memwrite_stall0", W_MEMWR);
        cyc(0, SW, 0, 0, "sw_memwrite_stall1", W_MEMWR);
        cyc(1, SW, 0, 1, "reset_mid_memwrite0", W_RST);
        cyc(1, SW, 0, 1, "reset_mid_memwrite1", W_RST);
        cyc(0, RT, 0, 1, "post_reset_fetch", W_F_RDY);
        // R-type, zero high in EXECUTER must not move the PC
        cyc(0, RT, 0, 1, "r_decode", W_DEC);
        cyc(0, RT, 1, 1, "r_executer", W_EXER);
        cyc(0, RT, 1, 1, "r_aluwb", W_ALUWB);
        cyc(0, IT, 0, 1, "r_next_fetch", W_F_RDY);
        // I-type
        cyc(0, IT, 0, 1, "i_decode", W_DEC);
        cyc(0, IT, 0, 1, "i_executei", W_EXEI);
        cyc(0, IT, 0, 1, "i_aluwb", W_ALUWB);
        cyc(0, LW, 0, 1, "i_next_fetch", W_F_RDY);
        // lw with 3 stall cycles in MEMREAD, then a fetch stall
        cyc(0, LW, 0, 1, "lw_decode", W_DEC);
        cyc(0, LW, 0, 1, "lw_memadr", W_MEMADR);
        cyc(0, LW, 0, 0, "lw_memread_stall0", W_MEMRD);
        cyc(0, LW, 0, 0, "lw_memread_stall1", W_MEMRD);
        cyc(0, LW, 0, 0, "lw_memread_stall2", W_MEMRD);
        cyc(0, LW, 0, 1, "lw_memread_done", W_MEMRD);
        cyc(0, LW, 0, 1, "lw_memwb", W_MEMWB);
        cyc(0, LW, 0, 0, "fetch_stall", W_F_STALL);
        cyc(0, SW, 0, 1, "fetch_after_stall", W_F_RDY);
        // sw without stall
        cyc(0, SW, 0, 1, "sw_decode", W_DEC);
        cyc(0, SW, 0, 1, "sw_memadr", W_MEMADR);
        cyc(0, SW, 0, 1, "sw_memwrite", W_MEMWR);
        cyc(0, JAL, 0, 1, "sw_next_fetch", W_F_RDY);
        // jal
        cyc(0, JAL, 0, 1, "jal_decode", W_DEC);
        cyc(0, JAL, 0, 1, "jal_state", W_JAL);
        cyc(0, JAL, 0, 1, "jal_aluwb", W_ALUWB);
        cyc(0, BEQ, 0, 1, "jal_next_fetch", W_F_RDY);
        // beq taken then not taken
        cyc(0, BEQ, 0, 1, "beq_t_decode", W_DEC);
        cyc(0, BEQ, 1, 1, "beq_taken", W_BEQ_T);
        cyc(0, BEQ, 0, 1, "beq_t_next_fetch", W_F_RDY);
        cyc(0, BEQ, 0, 1, "beq_n_decode", W_DEC);
        cyc(0, BEQ, 0, 1, "beq_not_taken", W_BEQ_N);
        cyc(0, 7'b0000000, 0, 1, "beq_n_next_fetch", W_F_RDY);
        // unsupported opcodes
        cyc(0, 7'b0000000, 0, 1, "illegal_00_decode", W_DEC_ILL);
        cyc(0, 7'b1111111, 0, 1, "illegal_00_fetch", W_F_RDY);
        cyc(0, 7'b1111111, 0, 1, "illegal_7f_decode", W_DEC_ILL);
        cyc(0, RT, 0, 1, "illegal_7f_fetch", W_F_RDY);
        cyc(0, RT, 0, 1, "final_decode", W_DEC);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d vectors left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
